seq_combo_lock: RTL and testbench
=================================

// Module: seq_combo_lock
// PURPOSE
//  Parametrised sequential combination lock for the Tiny Tapeout tile. Replaces a
//  single-cycle AND-of-keys match with an ordered multi-press code.
//  Adds per-press edge detection, a wrong-attempt counter with timed lockout,
//  a timed unlock window and a supervisor override.
//  key[] maps to ui_in; unlocked and alarm drive uo_out segment/LED bits in the
//  top-level wrapper.
// PARAMETERS
//  KEY_W           7        number of key inputs
//  IDX_W           3        key-index width; must satisfy 2**IDX_W >= KEY_W
//  CODE_LEN        4        presses per code, >= 1
//  CODE            12'hAB1  CODE_LEN x IDX_W key indices; step 0 in LSBs (default 1,6,2,5)
//  MAX_FAIL        3        wrong presses before lockout, >= 1
//  OPEN_CYCLES     16       cycles unlocked stays high after a correct code, >= 1
//  LOCKOUT_CYCLES  64       cycles alarm stays high in lockout, >= 1
// PORTS
//  clk        in   1                         clock
//  rst        in   1                         synchronous reset, active-high
//  key        in   KEY_W                     key levels, already synchronised to clk
//  override   in   1                         supervisor unlock / lockout clear
//  unlocked   out  1                         lock open
//  alarm      out  1                         lockout active
//  progress   out  $clog2(CODE_LEN+1)        correct presses so far this attempt
//  fail_cnt   out  $clog2(MAX_FAIL+1)        wrong presses since last success/clear
// BEHAVIOUR
//  - Reset: state ARMED; progress=0; fail_cnt=0; timer=0; alarm=0; key_q=all ones.
//    unlocked then equals override only.
//  - key_q is the key vector registered from the previous cycle. Its all-ones reset
//    value means keys held through reset produce no press.
//  - A press occurs in a cycle where key!=0 and key_q==0 (first key down after full release).
//    Keys changing while any key is held are ignored.
//  - Correct press: key is one-hot and the bit index equals CODE step[progress].
//    Every other press is wrong, including multiple simultaneous bits.
//  - ARMED:
//    - Correct press, progress<CODE_LEN-1: progress increments.
//    - Correct press, progress==CODE_LEN-1: go to OPEN; progress=0; fail_cnt=0;
//      timer=OPEN_CYCLES.
//    - Wrong press: progress=0; fail_cnt increments. If fail_cnt becomes MAX_FAIL,
//      go to LOCKOUT with timer=LOCKOUT_CYCLES.
//  - OPEN: presses ignored; timer decrements each cycle. Return to ARMED in the cycle
//    after timer==1, so the state is OPEN for exactly OPEN_CYCLES cycles.
//  - LOCKOUT: presses ignored; fail_cnt holds at MAX_FAIL; timer decrements.
//    Return to ARMED in the cycle after timer==1 with fail_cnt=0.
//  - Outputs:
//    - unlocked = (state==OPEN) | override. The override term is combinational.
//    - alarm = (state==LOCKOUT), registered.
//  - Latency: a press sampled at edge N gives new state/progress/alarm after edge N.
//    unlocked rises the cycle after the final correct press.
//  - override=1 in any state: next state ARMED; progress=0; fail_cnt=0; timer=0.
//    Override has priority over a simultaneous press. It aborts OPEN and LOCKOUT.
//  - rst has priority over override and over presses. Reset mid-entry or mid-lockout
//    discards all progress.
//  - Timer width is $clog2(max(OPEN_CYCLES,LOCKOUT_CYCLES)+1). No wrap: the timer
//    never decrements below 1 before the state exits.
// TESTING
//  - Press keys 1,6,2,5 (one cycle high, one cycle all released between presses)
//    -> progress 1,2,3; unlocked=1 for exactly 16 cycles; fail_cnt=0.
//  - Code 1,6,3 -> progress returns to 0 on the 3rd press; fail_cnt=1; no unlock.
//    Then 1,6,2,5 -> unlock and fail_cnt=0.
//  - Three wrong presses -> alarm=1 for exactly 64 cycles; presses ignored during
//    lockout; afterwards fail_cnt=0.
//  - key=7'b0000110 as a single press -> counted as wrong.
//    Hold key 1 while also pressing 6 -> no second press registered.
//  - Key held across rst release -> no press. override pulse during LOCKOUT ->
//    alarm=0 next cycle; unlocked high during the same cycle as override.
//  - Sweep KEY_W=4, CODE_LEN=1, MAX_FAIL=1 with a single matching press -> unlock;
//    a single wrong press -> immediate lockout.

Source files
------------

// File: rtl/seq_combo_lock.sv
`default_nettype none
// ============================================================================
// Module   : seq_combo_lock
// Brief    : Ordered multi-press combination lock with per-press edge
//            detection, wrong-attempt counter, timed lockout, timed unlock
//            window and a combinational supervisor override.
// Revision : 1.0 - initial release
// ============================================================================
module seq_combo_lock #(
    parameter int                          KEY_W          = 7,
    parameter int                          IDX_W          = 3,
    parameter int                          CODE_LEN       = 4,
    parameter logic [CODE_LEN*IDX_W-1:0]   CODE           = 12'hAB1,
    parameter int                          MAX_FAIL       = 3,
    parameter int                          OPEN_CYCLES    = 16,
    parameter int                          LOCKOUT_CYCLES = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [KEY_W-1:0]                  key,
    input  logic                              override,
    output logic                              unlocked,
    output logic                              alarm,
    output logic [$clog2(CODE_LEN+1)-1:0]     progress,
    output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt
);

    localparam int c_PW   = $clog2(CODE_LEN + 1);
    localparam int c_FW   = $clog2(MAX_FAIL + 1);
    localparam int c_TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int c_TW   = $clog2(c_TMAX + 1);

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    state_t             r_state,    w_state_nx;
    logic [c_PW-1:0]    r_progress, w_progress_nx;
    logic [c_FW-1:0]    r_fail,     w_fail_nx;
    logic [c_TW-1:0]    r_timer,    w_timer_nx;
    logic [KEY_W-1:0]   r_key_q;
    logic               r_alarm;

    logic               w_press;
    logic               w_onehot;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_step;
    logic               w_correct;

    // Press detection and decode of the pressed key against the current code step
    always_comb begin
        // A press needs a full release first; key_q resets to all ones so keys
        // held through reset never count.
        w_press  = (key != '0) && (r_key_q == '0);
        w_onehot = $onehot(key);
        w_idx    = '0;
        for (int i = 0; i < KEY_W; i++) begin
            if (key[i]) w_idx = IDX_W'(i);
        end
        w_step = '0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (r_progress == c_PW'(i)) w_step = CODE[i*IDX_W +: IDX_W];
        end
        w_correct = w_onehot && (w_idx == w_step);
    end

    // Next-state logic: override beats presses, timers count down to 1 then exit
    always_comb begin
        w_state_nx    = r_state;
        w_progress_nx = r_progress;
        w_fail_nx     = r_fail;
        w_timer_nx    = r_timer;
        if (override) begin
            w_state_nx    = ST_ARMED;
            w_progress_nx = '0;
            w_fail_nx     = '0;
            w_timer_nx    = '0;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (w_press) begin
                        if (w_correct) begin
                            if (r_progress == c_PW'(CODE_LEN - 1)) begin
                                w_state_nx    = ST_OPEN;
                                w_progress_nx = '0;
                                w_fail_nx     = '0;
                                w_timer_nx    = c_TW'(OPEN_CYCLES);
                            end else begin
                                w_progress_nx = r_progress + 1'b1;
                            end
                        end else begin
                            w_progress_nx = '0;
                            if (r_fail == c_FW'(MAX_FAIL - 1)) begin
                                w_state_nx = ST_LOCKOUT;
                                w_fail_nx  = c_FW'(MAX_FAIL);
                                w_timer_nx = c_TW'(LOCKOUT_CYCLES);
                            end else begin
                                w_fail_nx = r_fail + 1'b1;
                            end
                        end
                    end
                end
                ST_OPEN: begin
                    if (r_timer == c_TW'(1)) begin
                        w_state_nx = ST_ARMED;
                        w_timer_nx = '0;
                    end else begin
                        w_timer_nx = r_timer - 1'b1;
                    end
                end
                ST_LOCKOUT: begin
                    if (r_timer == c_TW'(1)) begin
                        w_state_nx = ST_ARMED;
                        w_fail_nx  = '0;
                        w_timer_nx = '0;
                    end else begin
                        w_timer_nx = r_timer - 1'b1;
                    end
                end
                default: begin
                    w_state_nx    = ST_ARMED;
                    w_progress_nx = '0;
                    w_fail_nx     = '0;
                    w_timer_nx    = '0;
                end
            endcase
        end
    end

    // State register; reset has priority over override and presses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_ARMED;
            r_progress <= '0;
            r_fail     <= '0;
            r_timer    <= '0;
            r_alarm    <= 1'b0;
            r_key_q    <= '1;
        end else begin
            r_state    <= w_state_nx;
            r_progress <= w_progress_nx;
            r_fail     <= w_fail_nx;
            r_timer    <= w_timer_nx;
            r_alarm    <= (w_state_nx == ST_LOCKOUT);
            r_key_q    <= key;
        end
    end

    assign unlocked = (r_state == ST_OPEN) | override;
    assign alarm    = r_alarm;
    assign progress = r_progress;
    assign fail_cnt = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_seq_combo_lock.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_combo_lock
// Brief    : Self-checking bench for seq_combo_lock (default build plus a
//            KEY_W=4 / CODE_LEN=1 / MAX_FAIL=1 build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_combo_lock;

    typedef struct {
        logic       rst;
        logic       sel;     // 0: default build, 1: small build
        logic [6:0] key;
        logic       ovr;
        logic       eu;
        logic       ea;
        logic [2:0] ep;
        logic [1:0] ef;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] key_a = '0;
    logic       ovr_a = 1'b0;
    logic       unl_a, alm_a;
    logic [2:0] prog_a;
    logic [1:0] fail_a;
    logic [3:0] key_b = '0;
    logic       ovr_b = 1'b0;
    logic       unl_b, alm_b;
    logic [0:0] prog_b;
    logic [0:0] fail_b;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[$];
    vec_t sb_q[$];

    always #5 clk = ~clk;

    seq_combo_lock u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .key      (key_a),
        .override (ovr_a),
        .unlocked (unl_a),
        .alarm    (alm_a),
        .progress (prog_a),
        .fail_cnt (fail_a)
    );

    seq_combo_lock #(
        .KEY_W          (4),
        .IDX_W          (2),
        .CODE_LEN       (1),
        .CODE           (2'd2),
        .MAX_FAIL       (1),
        .OPEN_CYCLES    (4),
        .LOCKOUT_CYCLES (5)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .key      (key_b),
        .override (ovr_b),
        .unlocked (unl_b),
        .alarm    (alm_b),
        .progress (prog_b),
        .fail_cnt (fail_b)
    );

    function automatic void add(input logic r, input logic s, input logic [6:0] k,
                                input logic o, input logic u, input logic a,
                                input logic [2:0] p, input logic [1:0] f);
        vec_t v;
        v.rst = r; v.sel = s; v.key = k; v.ovr = o;
        v.eu = u; v.ea = a; v.ep = p; v.ef = f;
        vecs.push_back(v);
    endfunction

    // Drive one cycle of stimulus, queue its expectation, compare after the edge
    task automatic step(input vec_t v);
        vec_t       e;
        logic       gu, ga;
        logic [2:0] gp;
        logic [1:0] gf;
        @(negedge clk);
        rst   = v.rst;
        key_a = v.sel ? 7'd0 : v.key;
        ovr_a = v.sel ? 1'b0 : v.ovr;
        key_b = v.sel ? v.key[3:0] : 4'd0;
        ovr_b = v.sel ? v.ovr : 1'b0;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        if (e.sel) begin
            gu = unl_b; ga = alm_b; gp = {2'b00, prog_b}; gf = {1'b0, fail_b};
        end else begin
            gu = unl_a; ga = alm_a; gp = prog_a; gf = fail_a;
        end
        n_vec++;
        if ({gu, ga, gp, gf} !== {e.eu, e.ea, e.ep, e.ef}) begin
            n_err++;
            $display("FAIL vec%0d dut%0d: got u=%b a=%b p=%0d f=%0d, want u=%b a=%b p=%0d f=%0d",
                     n_vec, e.sel, gu, ga, gp, gf, e.eu, e.ea, e.ep, e.ef);
        end
    endtask

    task automatic a_row(input logic [6:0] k, input logic o, input logic u,
                         input logic a, input logic [2:0] p, input logic [1:0] f);
        vec_t v;
        v.rst = 1'b0; v.sel = 1'b0; v.key = k; v.ovr = o;
        v.eu = u; v.ea = a; v.ep = p; v.ef = f;
        step(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        add(1, 0, 7'h00, 0, 0, 0, 0, 0);
        add(1, 0, 7'h00, 0, 0, 0, 0, 0);
        // correct code 1,6,2,5 then 16-cycle open window
        add(0, 0, 7'h00, 0, 0, 0, 0, 0);
        add(0, 0, 7'h02, 0, 0, 0, 1, 0);
        add(0, 0, 7'h00, 0, 0, 0, 1, 0);
        add(0, 0, 7'h40, 0, 0, 0, 2, 0);
        add(0, 0, 7'h00, 0, 0, 0, 2, 0);
        add(0, 0, 7'h04, 0, 0, 0, 3, 0);
        add(0, 0, 7'h00, 0, 0, 0, 3, 0);
        add(0, 0, 7'h20, 0, 1, 0, 0, 0);
        for (int i = 0; i < 15; i++) add(0, 0, 7'h00, 0, 1, 0, 0, 0);
        add(0, 0, 7'h00, 0, 0, 0, 0, 0);
        // wrong code 1,6,3 then the correct code
        add(0, 0, 7'h02, 0, 0, 0, 1, 0);
        add(0, 0, 7'h00, 0, 0, 0, 1, 0);
        add(0, 0, 7'h40, 0, 0, 0, 2, 0);
        add(0, 0, 7'h00, 0, 0, 0, 2, 0);
        add(0, 0, 7'h08, 0, 0, 0, 0, 1);
        add(0, 0, 7'h00, 0, 0, 0, 0, 1);
        add(0, 0, 7'h02, 0, 0, 0, 1, 1);
        add(0, 0, 7'h00, 0, 0, 0, 1, 1);
        add(0, 0, 7'h40, 0, 0, 0, 2, 1);
        add(0, 0, 7'h00, 0, 0, 0, 2, 1);
        add(0, 0, 7'h04, 0, 0, 0, 3, 1);
        add(0, 0, 7'h00, 0, 0, 0, 3, 1);
        add(0, 0, 7'h20, 0, 1, 0, 0, 0);
        // presses during OPEN are ignored
        for (int i = 0; i < 15; i++)
            add(0, 0, (i == 4) ? 7'h02 : 7'h00, 0, 1, 0, 0, 0);
        add(0, 0, 7'h00, 0, 0, 0, 0, 0);
        // three wrong presses -> 64-cycle lockout, presses ignored meanwhile
        add(0, 0, 7'h08, 0, 0, 0, 0, 1);
        add(0, 0, 7'h00, 0, 0, 0, 0, 1);
        add(0, 0, 7'h08, 0, 0, 0, 0, 2);
        add(0, 0, 7'h00, 0, 0, 0, 0, 2);
        add(0, 0, 7'h08, 0, 0, 1, 0, 3);
        for (int i = 0; i < 63; i++)
            add(0, 0, ((i % 4) == 1 && i < 60) ? 7'h02 : 7'h00, 0, 0, 1, 0, 3);
        add(0, 0, 7'h00, 0, 0, 0, 0, 0);
        // multi-bit press is wrong; keys changing while held are ignored
        add(0, 0, 7'h06, 0, 0, 0, 0, 1);
        add(0, 0, 7'h00, 0, 0, 0, 0, 1);
        add(0, 0, 7'h02, 0, 0, 0, 1, 1);
        add(0, 0, 7'h42, 0, 0, 0, 1, 1);
        add(0, 0, 7'h02, 0, 0, 0, 1, 1);
        add(0, 0, 7'h00, 0, 0, 0, 1, 1);
        add(0, 0, 7'h40, 0, 0, 0, 2, 1);
        add(0, 0, 7'h00, 0, 0, 0, 2, 1);
        // reset mid-entry with a key held across release
        add(1, 0, 7'h02, 0, 0, 0, 0, 0);
        add(1, 0, 7'h02, 0, 0, 0, 0, 0);
        add(0, 0, 7'h02, 0, 0, 0, 0, 0);
        add(0, 0, 7'h02, 0, 0, 0, 0, 0);
        add(0, 0, 7'h00, 0, 0, 0, 0, 0);
        add(0, 0, 7'h02, 0, 0, 0, 1, 0);
        add(0, 0, 7'h00, 0, 0, 0, 1, 0);
        // small build: single matching press opens for 4 cycles
        add(0, 1, 7'h00, 0, 0, 0, 0, 0);
        add(0, 1, 7'h04, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 7'h00, 0, 1, 0, 0, 0);
        add(0, 1, 7'h00, 0, 0, 0, 0, 0);
        // small build: single wrong press locks out for 5 cycles
        add(0, 1, 7'h01, 0, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) add(0, 1, 7'h00, 0, 0, 1, 0, 1);
        add(0, 1, 7'h00, 0, 0, 0, 0, 0);

        foreach (vecs[i]) step(vecs[i]);

        // Hand sequence: override pulse during lockout
        a_row(7'h08, 0, 0, 0, 0, 1);
        a_row(7'h00, 0, 0, 0, 0, 1);
        a_row(7'h08, 0, 0, 0, 0, 2);
        a_row(7'h00, 0, 0, 0, 0, 2);
        a_row(7'h08, 0, 0, 1, 0, 3);
        a_row(7'h00, 0, 0, 1, 0, 3);
        a_row(7'h00, 0, 0, 1, 0, 3);
        // override raised mid-cycle: unlocked follows at once, alarm still set
        @(negedge clk);
        ovr_a = 1'b1;
        #1;
        n_vec++;
        if ({unl_a, alm_a} !== 2'b11) begin
            n_err++;
            $display("FAIL ovr_same_cycle: got u=%b a=%b, want u=1 a=1", unl_a, alm_a);
        end
        // the edge with override held clears lockout and counters
        begin
            vec_t v;
            v.rst = 0; v.sel = 0; v.key = 7'h00; v.ovr = 1;
            v.eu = 1; v.ea = 0; v.ep = 0; v.ef = 0;
            sb_q.push_back(v);
            @(posedge clk);
            #1;
            v = sb_q.pop_front();
            n_vec++;
            if ({unl_a, alm_a, prog_a, fail_a} !== {v.eu, v.ea, v.ep, v.ef}) begin
                n_err++;
                $display("FAIL ovr_edge: got u=%b a=%b p=%0d f=%0d, want u=1 a=0 p=0 f=0",
                         unl_a, alm_a, prog_a, fail_a);
            end
        end
        a_row(7'h00, 0, 0, 0, 0, 0);
        a_row(7'h02, 0, 0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
